// File: rtl/usbfs_serial_tx_arb_if.sv
// Handshake bundle between byte producers, the tx arbiter and the serial endpoint.
// The slave modport is the arbiter's view; the master modport drives it.
interface usbfs_serial_tx_arb_if #(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0]   i_req_valid;
    logic [N_REQ-1:0]   o_req_ready;
    logic [8*N_REQ-1:0] i_req_data;
    logic               o_valid;
    logic               i_ready;
    logic [7:0]         o_data;
    logic [N_REQ-1:0]   o_grant;
    logic               o_busy;

    modport slave (
        input  i_req_valid, i_req_data, i_ready,
        output o_req_ready, o_valid, o_data, o_grant, o_busy
    );

    modport master (
        output i_req_valid, i_req_data, i_ready,
        input  o_req_ready, o_valid, o_data, o_grant, o_busy
    );
endinterface

// File: rtl/usbfs_serial_tx_arb.sv
// Round-robin burst arbiter merging N_REQ byte streams onto the USB devToHost stream.
// Define USBFS_SERIAL_TX_ARB_HDR_EN to prefix every burst with a {4'hA, grant} header byte.
module usbfs_serial_tx_arb #(
    parameter int N_REQ     = 4,
    parameter int BURST_MAX = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    usbfs_serial_tx_arb_if.slave  bus
);
    localparam int IDX_W = $clog2(N_REQ);
    localparam int CNT_W = $clog2(BURST_MAX) + 1;

    typedef enum logic [1:0] {S_IDLE, S_HDR, S_BURST} state_e;

    state_e                     state_q;
    logic [IDX_W-1:0]           grant_idx_q;
    logic [N_REQ-1:0]           grant_q;
    logic [IDX_W-1:0]           rr_idx_q;
    logic [CNT_W-1:0]           cnt_q;

    logic [N_REQ-1:0][7:0]      req_bytes;
    logic                       pick_vld;
    logic [IDX_W-1:0]           pick_idx;
    logic                       g_valid;

    assign req_bytes = bus.i_req_data;
    assign g_valid   = bus.i_req_valid[grant_idx_q];

    // Descending scan so the requester closest to rr_idx (upward, wrapping) wins last.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            int j;
            j = int'(rr_idx_q) + i;
            if (j >= N_REQ) j = j - N_REQ;
            if (bus.i_req_valid[j]) begin
                pick_vld = 1'b1;
                pick_idx = IDX_W'(j);
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= S_IDLE;
            grant_idx_q <= '0;
            grant_q     <= '0;
            rr_idx_q    <= '0;
            cnt_q       <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (pick_vld) begin
                        grant_idx_q <= pick_idx;
                        grant_q     <= N_REQ'(1) << pick_idx;
                        cnt_q       <= '0;
`ifdef USBFS_SERIAL_TX_ARB_HDR_EN
                        state_q     <= S_HDR;
`else
                        state_q     <= S_BURST;
`endif
                    end
                end
`ifdef USBFS_SERIAL_TX_ARB_HDR_EN
                S_HDR: begin
                    if (bus.i_ready) state_q <= S_BURST;
                end
`endif
                S_BURST: begin
                    // An idle requester and a final counted transfer both end the burst here, once.
                    if (!g_valid || (bus.i_ready && cnt_q == CNT_W'(BURST_MAX - 1))) begin
                        state_q  <= S_IDLE;
                        grant_q  <= '0;
                        rr_idx_q <= (grant_idx_q == IDX_W'(N_REQ - 1)) ? '0 : grant_idx_q + 1'b1;
                    end else if (bus.i_ready) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        bus.o_valid     = 1'b0;
        bus.o_data      = 8'h00;
        bus.o_req_ready = '0;
        case (state_q)
            S_BURST: begin
                bus.o_valid     = g_valid;
                bus.o_data      = req_bytes[grant_idx_q];
                bus.o_req_ready = grant_q & {N_REQ{bus.i_ready}};
            end
`ifdef USBFS_SERIAL_TX_ARB_HDR_EN
            S_HDR: begin
                bus.o_valid = 1'b1;
                bus.o_data  = {4'hA, 4'(grant_idx_q)};
            end
`endif
            default: ;
        endcase
    end

    assign bus.o_grant = grant_q;
    assign bus.o_busy  = (state_q != S_IDLE);
endmodule

// File: tb/tb_usbfs_serial_tx_arb.sv
// Directed bench for usbfs_serial_tx_arb: per-requester source queues feed the DUT,
// expected output bytes and burst lengths are queued as stimulus is planned.
module tb_usbfs_serial_tx_arb;
    localparam int N  = 4;
    localparam int BM = 8;
`ifdef USBFS_SERIAL_TX_ARB_HDR_EN
    localparam int HDR_X = 1;
`else
    localparam int HDR_X = 0;
`endif

    typedef struct {
        int         g;
        logic [7:0] d;
    } exp_t;

    logic i_clk = 1'b0;
    logic i_rst;

    usbfs_serial_tx_arb_if #(.N_REQ(N)) bus ();

    usbfs_serial_tx_arb #(.N_REQ(N), .BURST_MAX(BM)) dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus)
    );

    always #5 i_clk = ~i_clk;

    logic [7:0] src [N][$];
    exp_t       exp_q [$];
    int         len_q [$];
    int         errors = 0;
    int         checks = 0;
    int         run_len = 0;
    int         nxfer = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic drive();
        for (int r = 0; r < N; r++) begin
            bus.i_req_valid[r]        = (src[r].size() != 0);
            bus.i_req_data[8*r +: 8]  = (src[r].size() != 0) ? src[r][0] : 8'h00;
        end
    endtask

    task automatic load(input int r, input int start, input int n);
        for (int i = 0; i < n; i++) src[r].push_back(8'(start + i));
        drive();
    endtask

    task automatic push_burst(input int g, input int start, input int n, input bit with_len);
        exp_t e;
        if (HDR_X != 0) begin
            e.g = g; e.d = 8'hA0 | 8'(g);
            exp_q.push_back(e);
        end
        for (int i = 0; i < n; i++) begin
            e.g = g; e.d = 8'(start + i);
            exp_q.push_back(e);
        end
        if (with_len) len_q.push_back(n + HDR_X);
    endtask

    // One clock: checks at the falling edge, source pops just after the rising edge.
    task automatic step();
        logic [N-1:0] xfer;
        exp_t e;
        @(negedge i_clk);
        if (bus.o_grant == '0) begin
            chk("idle_valid", 32'(bus.o_valid), 32'd0);
            if (run_len != 0) begin
                if (len_q.size() == 0) chk("burst_len_unexpected", 32'(run_len), 32'd0);
                else chk("burst_len", 32'(run_len), 32'(len_q.pop_front()));
            end
            run_len = 0;
        end
        chk("ready_only_granted", 32'(bus.o_req_ready & ~bus.o_grant), 32'd0);
        if (bus.o_valid && bus.i_ready) begin
            if (exp_q.size() == 0) chk("unexpected_byte", 32'(bus.o_data), 32'hFFFF);
            else begin
                e = exp_q.pop_front();
                chk("data", 32'(bus.o_data), 32'(e.d));
                chk("grant", 32'(bus.o_grant), 32'(1) << e.g);
            end
            run_len++;
            nxfer++;
        end
        xfer = bus.o_req_ready & bus.i_req_valid;
        @(posedge i_clk);
        #1;
        for (int r = 0; r < N; r++) if (xfer[r]) void'(src[r].pop_front());
        drive();
    endtask

    task automatic drain(input string tag);
        int k = 0;
        while ((exp_q.size() != 0 || len_q.size() != 0) && k < 300) begin
            step();
            k++;
        end
        chk({tag, "_timeout"}, 32'(k < 300), 32'd1);
    endtask

    initial begin
        int target;
        int k;
        i_rst            = 1'b1;
        bus.i_ready      = 1'b1;
        bus.i_req_valid  = '0;
        bus.i_req_data   = '0;
        #12;
        chk("rst_valid", 32'(bus.o_valid), 32'd0);
        chk("rst_ready", 32'(bus.o_req_ready), 32'd0);
        chk("rst_data",  32'(bus.o_data), 32'd0);
        chk("rst_busy",  32'(bus.o_busy), 32'd0);
        chk("rst_grant", 32'(bus.o_grant), 32'd0);
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;

        // Two continuously valid requesters alternate, 8 bytes each, starting at req0.
        load(0, 8'h20, 24);
        load(2, 8'h40, 24);
        push_burst(0, 8'h20, 8, 1); push_burst(2, 8'h40, 8, 1);
        push_burst(0, 8'h28, 8, 1); push_burst(2, 8'h48, 8, 1);
        push_burst(0, 8'h30, 8, 1); push_burst(2, 8'h50, 8, 1);
        drain("alt");

        // Single requester, 20 bytes -> bursts of 8, 8, 4.
        load(0, 8'h00, 20);
        push_burst(0, 8'h00, 8, 1);
        push_burst(0, 8'h08, 8, 1);
        push_burst(0, 8'h10, 4, 1);
        drain("stream20");

        // Backpressure mid-burst on req1.
        load(1, 8'hA0, 8);
        push_burst(1, 8'hA0, 8, 1);
        repeat (3) step();
        bus.i_ready = 1'b0;
        repeat (5) begin
            step();
            chk("stall_valid", 32'(bus.o_valid), 32'd1);
            chk("stall_data", 32'(bus.o_data), 32'(exp_q[0].d));
            chk("stall_ready", 32'(bus.o_req_ready), 32'd0);
        end
        bus.i_ready = 1'b1;
        drain("stall");

        // req3 goes idle after 3 bytes; search then wraps to req0 ahead of req1.
        load(3, 8'hC0, 3);
        push_burst(3, 8'hC0, 3, 1);
        drain("drop");
        load(0, 8'hD0, 2);
        load(1, 8'hE0, 2);
        push_burst(0, 8'hD0, 2, 1);
        push_burst(1, 8'hE0, 2, 1);
        drain("wrap");

        // Reset mid-burst after 4 payload bytes; arbitration restarts at req0.
        load(2, 8'h60, 8);
        push_burst(2, 8'h60, 4, 0);
        target = nxfer + 4 + HDR_X;
        k = 0;
        while (nxfer < target && k < 100) begin
            step();
            k++;
        end
        chk("rst_wait", 32'(nxfer >= target), 32'd1);
        i_rst = 1'b1;
        #1;
        chk("midrst_valid", 32'(bus.o_valid), 32'd0);
        chk("midrst_grant", 32'(bus.o_grant), 32'd0);
        chk("midrst_ready", 32'(bus.o_req_ready), 32'd0);
        chk("midrst_busy",  32'(bus.o_busy), 32'd0);
        src[2].delete();
        run_len = 0;
        drive();
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        load(3, 8'h70, 2);
        load(1, 8'h80, 2);
        push_burst(1, 8'h80, 2, 1);
        push_burst(3, 8'h70, 2, 1);
        drain("post_rst");

`ifdef USBFS_SERIAL_TX_ARB_HDR_EN
        // Header held under backpressure must not leak ready to the requester.
        bus.i_ready = 1'b0;
        load(2, 8'h90, 2);
        push_burst(2, 8'h90, 2, 1);
        step();
        repeat (3) begin
            step();
            chk("hdr_valid", 32'(bus.o_valid), 32'd1);
            chk("hdr_data", 32'(bus.o_data), 32'hA2);
            chk("hdr_ready", 32'(bus.o_req_ready), 32'd0);
        end
        bus.i_ready = 1'b1;
        drain("hdr");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
